// File: rtl/md_unit_if.sv
// Request/response bundle between ID/EX and the multiply/divide unit.
// The unit takes the slave side; the pipeline (or a bench) drives the master side.
interface md_unit_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [1:0]       md_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             wr_hi;
    logic             wr_lo;
    logic             busy;
    logic             md_stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, src_a, src_b, wr_hi, wr_lo,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b, wr_hi, wr_lo,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Accepted ops always run a fixed number of cycles and then commit to HI/LO.
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave io_md
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        StIdle,
        StBusy
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_mag_b_safe;
    logic [WIDTH-1:0]   w_uquot;
    logic [WIDTH-1:0]   w_urem;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_zero;
    logic [2*WIDTH-1:0] w_result;

    // md_op[0] selects the unsigned variant for both mult and div.
    assign w_signed = ~r_op[0];

    // Sign- or zero-extend so one 2*WIDTH multiplier serves mult and multu.
    assign w_ext_a = {{WIDTH{w_signed & r_a[WIDTH-1]}}, r_a};
    assign w_ext_b = {{WIDTH{w_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide on magnitudes, then restore signs; this also yields
    // 0x80000000 / -1 = 0x80000000 rem 0 without overflow special-casing.
    assign w_neg_a      = w_signed & r_a[WIDTH-1];
    assign w_neg_b      = w_signed & r_b[WIDTH-1];
    assign w_mag_a      = w_neg_a ? -r_a : r_a;
    assign w_mag_b      = w_neg_b ? -r_b : r_b;
    assign w_div_zero   = (r_b == '0);
    assign w_mag_b_safe = w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
    assign w_uquot      = w_mag_a / w_mag_b_safe;
    assign w_urem       = w_mag_a % w_mag_b_safe;
    assign w_quot       = (w_neg_a ^ w_neg_b) ? -w_uquot : w_uquot;
    assign w_rem        = w_neg_a ? -w_urem : w_urem;

    assign w_result = r_op[1] ? {w_rem, w_quot} : w_prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (io_md.start) begin
                        r_state <= StBusy;
                        r_busy  <= 1'b1;
                        r_op    <= io_md.md_op;
                        r_a     <= io_md.src_a;
                        r_b     <= io_md.src_b;
                        r_count <= io_md.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else begin
                        if (io_md.wr_hi) r_hi <= io_md.src_a;
                        if (io_md.wr_lo) r_lo <= io_md.src_a;
                    end
                end
                StBusy: begin
                    if (r_count == CNT_W'(1)) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                        // Divide by zero burns its cycles but leaves HI/LO alone.
                        if (!(r_op[1] && w_div_zero)) begin
                            r_hi <= w_result[2*WIDTH-1:WIDTH];
                            r_lo <= w_result[WIDTH-1:0];
                        end
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_md.busy     = r_busy;
    assign io_md.md_stall = io_md.start | r_busy;
    assign io_md.hi       = r_hi;
    assign io_md.lo       = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// Directed and random checks of md_unit against an arithmetic reference model.
module tb_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

    md_unit_if #(.WIDTH(32)) bus ();

    md_unit #(
        .WIDTH      (32),
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io_md(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {hi,lo} after op, from plain integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {hi, lo};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic write_hilo(input bit h, input bit l, input logic [31:0] v);
        bus.wr_hi = h;
        bus.wr_lo = l;
        bus.src_a = v;
        tick();
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        if (h) ref_hi = v;
        if (l) ref_lo = v;
        check("mt_hilo", {bus.hi, bus.lo}, {ref_hi, ref_lo});
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit with_wr);
        int n;
        logic [63:0] exp;
        n   = op[1] ? DIV_N : MULT_N;
        exp = ref_md(op, a, b, ref_hi, ref_lo);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.wr_hi = with_wr;
        bus.wr_lo = with_wr;
        #1;
        check("stall_start", 64'(bus.md_stall), 64'd1);
        tick();
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        for (int k = 0; k < n; k++) begin
            check("busy_stall", 64'({bus.busy, bus.md_stall}), 64'b11);
            check("hold_hilo", {bus.hi, bus.lo}, {ref_hi, ref_lo});
            tick();
        end
        check("done_idle", 64'({bus.busy, bus.md_stall}), 64'b00);
        ref_hi = exp[63:32];
        ref_lo = exp[31:0];
        check("result", {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        logic [63:0] mexp;
        checks    = 0;
        errors    = 0;
        ref_hi    = '0;
        ref_lo    = '0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.md_op = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        tick();
        tick();
        check("reset_state", {30'b0, bus.busy, bus.md_stall, bus.hi ^ bus.lo}, 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        tick();

        // Signed/unsigned multiply.
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_lit", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_lit", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);

        // Divides.
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lit", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd7, 32'd2, 1'b0);
        check("divu_lit", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);

        // Divide by zero keeps HI/LO; overflow case.
        write_hilo(1'b1, 1'b0, 32'h11);
        write_hilo(1'b0, 1'b1, 32'h22);
        run_op(2'b11, 32'd99, 32'd0, 1'b0);
        check("divz_lit", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lit", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // start and wr_hi while busy are ignored.
        mexp = ref_md(2'b00, 32'd5, 32'd7, ref_hi, ref_lo);
        bus.start = 1'b1;
        bus.md_op = 2'b00;
        bus.src_a = 32'd5;
        bus.src_b = 32'd7;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.md_op = 2'b10;
        bus.src_a = 32'hAB;
        bus.src_b = 32'd3;
        bus.wr_hi = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        check("busy_ignore_wr", {bus.hi, bus.lo}, {ref_hi, ref_lo});
        tick();
        tick();
        check("busy_c4", 64'(bus.busy), 64'd1);
        tick();
        check("mult_c5_done", 64'(bus.busy), 64'd0);
        check("mult_c5_res", {bus.hi, bus.lo}, mexp);
        ref_hi = mexp[63:32];
        ref_lo = mexp[31:0];
        tick();
        check("no_late_div", {31'b0, bus.busy, bus.hi, bus.lo}, {32'b0, ref_hi, ref_lo});

        write_hilo(1'b1, 1'b1, 32'h5);
        check("both_lit", {bus.hi, bus.lo}, 64'h0000_0005_0000_0005);

        // start with wr_hi/wr_lo: start wins.
        run_op(2'b01, 32'd6, 32'd9, 1'b1);

        // Asynchronous reset in the middle of a divide.
        write_hilo(1'b1, 1'b1, 32'h1234);
        bus.start = 1'b1;
        bus.md_op = 2'b11;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", {31'b0, bus.busy, bus.hi, bus.lo}, 64'd0);
        ref_hi = '0;
        ref_lo = '0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", 64'(bus.busy), 64'd0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);

        // Random ops against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0)
                write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op(op, a, b, ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
